// File: rtl/sp_ram_arb_pkg.sv
// sp_ram_arb shared types: RAM wrapper geometry,
// per-port request bundle and index-width helper.
package sp_ram_arb_pkg;

  localparam int unsigned RAM_AW = 15;
  localparam int unsigned RAM_DW = 32;
  localparam int unsigned RAM_BW = RAM_DW / 8;
  localparam int unsigned MAX_PORTS = 8;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic              we;
    logic [RAM_BW-1:0] be;
    logic [RAM_DW-1:0] wdata;
  } ram_req_t;

  // Port index width, never below 1 bit.
  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_rr_sel.sv
// Combinational round-robin picker.
// req/last in; one-hot gnt, idx, any out.
module sp_ram_rr_sel
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  localparam logic [NUM_PORTS-1:0] ONE =
    {{(NUM_PORTS-1){1'b0}}, 1'b1};

  logic [NUM_PORTS-1:0] rot;
  int                   sh;
  int                   off;
  int                   win;

  // Rotate so bit 0 is port last+1, then
  // take the lowest set bit.
  always_comb begin
    sh  = (int'(last) + 1) % int'(NUM_PORTS);
    rot = NUM_PORTS'({req, req} >> sh);
    off = 0;
    any = 1'b0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        off = i;
      end
    end
    win = (sh + off) % int'(NUM_PORTS);
    idx = any ? IDX_W'(win) : '0;
    gnt = any ? (ONE << idx) : '0;
  end

endmodule

// File: rtl/sp_ram_arb.sv
// Round-robin arbiter sharing one single-port RAM
// between NUM_PORTS req/gnt/rvalid requesters.
module sp_ram_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = RAM_AW,
  parameter int unsigned DATA_WIDTH = RAM_DW
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0]
               [ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0] we_i,
  input  logic [NUM_PORTS-1:0]
               [DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0]
               [DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [NUM_PORTS-1:0] rvalid_o,
  output logic [NUM_PORTS-1:0]
               [DATA_WIDTH-1:0] rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int unsigned PORT_IDX_W =
    idx_w(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE =
    {{(NUM_PORTS-1){1'b0}}, 1'b1};

  ram_req_t               port_req [NUM_PORTS];
  ram_req_t               sel;
  logic [PORT_IDX_W-1:0]  idx;
  logic                   any;
  logic [PORT_IDX_W-1:0]  last_q;
  logic [PORT_IDX_W-1:0]  rid_q;
  logic                   rv_q;

  sp_ram_rr_sel #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (PORT_IDX_W)
  ) u_sel (
    .req  (req_i),
    .last (last_q),
    .gnt  (gnt_o),
    .idx  (idx),
    .any  (any)
  );

  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      port_req[i].addr  = addr_i[i];
      port_req[i].we    = we_i[i];
      port_req[i].be    = be_i[i];
      port_req[i].wdata = wdata_i[i];
    end
  end

  // One-hot grant: OR of masked bundles is a
  // mux that is all-zero when nothing wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (gnt_o[i]) sel = sel | port_req[i];
    end
  end

  assign ram_en_o    = |req_i;
  assign ram_addr_o  = sel.addr;
  assign ram_we_o    = sel.we;
  assign ram_wdata_o = sel.wdata;
  assign ram_be_o    = !any   ? '0      :
                       sel.we ? sel.be  : '1;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= PORT_IDX_W'(NUM_PORTS - 1);
      rid_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      rv_q  <= any;
      rid_q <= idx;
      if (any) last_q <= idx;
    end
  end

  assign rvalid_o = rv_q ? (ONE << rid_q) : '0;
  assign rdata_o  = {NUM_PORTS{ram_rdata_i}};

endmodule

// File: tb/tb_sp_ram_arb.sv
// Directed + random bench for sp_ram_arb
// with 3 ports and a behavioural 1-cycle RAM.
module tb_sp_ram_arb;

  localparam int NP = 3;

  logic                  clk = 1'b0;
  logic                  rstn_i;
  logic [NP-1:0]         req;
  logic [NP-1:0][14:0]   addr;
  logic [NP-1:0]         we;
  logic [NP-1:0][3:0]    be;
  logic [NP-1:0][31:0]   wdata;
  logic [NP-1:0]         gnt;
  logic [NP-1:0]         rvalid;
  logic [NP-1:0][31:0]   rdata;
  logic                  ram_en;
  logic [14:0]           ram_addr;
  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  logic                  ld_en;
  logic [12:0]           ld_idx;
  logic [31:0]           ld_val;
  logic [31:0]           mem [0:8191];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  sp_ram_arb #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (15),
    .DATA_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .req_i       (req),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_val;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr[14:2]];
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b])
            mem[ram_addr[14:2]][b*8 +: 8]
              <= ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic preload(
    input logic [12:0] i,
    input logic [31:0] v
  );
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = i;
    ld_val = v;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  task automatic set_port(
    input int          p,
    input logic        r,
    input logic [14:0] a,
    input logic        w,
    input logic [3:0]  b,
    input logic [31:0] d
  );
    req[p]   = r;
    addr[p]  = a;
    we[p]    = w;
    be[p]    = b;
    wdata[p] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i = 1'b0;
    req    = '0;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  // Called just after a negedge drive.
  // Checks grant now, response after posedge.
  task automatic cyc(
    input string       tag,
    input logic [2:0]  eg,
    input bit          cd,
    input int          dp,
    input logic [31:0] ed
  );
    #1;
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_en"}, ram_en, |req);
    @(posedge clk);
    #1;
    check({tag, "_rv"}, rvalid, eg);
    if (cd) check({tag, "_rd"}, rdata[dp], ed);
  endtask

  logic [2:0] idle_req [11];
  logic [2:0] idle_exp [11];
  logic [2:0] cont_exp [6];

  logic [NP-1:0] pend;
  logic [NP-1:0] g;
  int            waitc [NP];
  int            maxw, bad_g, bad_rv;
  int            n_g, n_rv;

  initial begin
    rstn_i = 1'b0;
    req    = '0;
    addr   = '0;
    we     = '0;
    be     = '0;
    wdata  = '0;
    ld_en  = 1'b0;
    ld_idx = '0;
    ld_val = '0;

    preload(13'd4,  32'hDEADBEEF);
    preload(13'd8,  32'h11223344);
    preload(13'd16, 32'hA0A0A0A0);
    preload(13'd17, 32'hB1B1B1B1);

    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rv",  rvalid, 0);
    check("rst_en",  ram_en, 0);
    @(negedge clk);
    rstn_i = 1'b1;

    // Contention from reset: 0 wins first.
    cont_exp = '{3'b001, 3'b010, 3'b001,
                 3'b010, 3'b001, 3'b010};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_port(0, 1, 15'h40, 0, 4'h0, 0);
      set_port(1, 1, 15'h44, 0, 4'h0, 0);
      cyc($sformatf("cont%0d", i), cont_exp[i], 1,
          cont_exp[i][0] ? 0 : 1,
          cont_exp[i][0] ? 32'hA0A0A0A0
                         : 32'hB1B1B1B1);
    end
    @(negedge clk);
    req = '0;
    cyc("cont_idle", 3'b000, 0, 0, 0);

    // Single read.
    @(negedge clk);
    set_port(0, 1, 15'h10, 0, 4'h0, 0);
    #1;
    check("rd_addr", ram_addr, 15'h10);
    check("rd_be",   ram_be, 4'hF);
    check("rd_we",   ram_we, 0);
    cyc("rd", 3'b001, 1, 0, 32'hDEADBEEF);

    // Byte write then read-back.
    @(negedge clk);
    req = '0;
    set_port(1, 1, 15'h20, 1, 4'h1, 32'hAA);
    #1;
    check("wr_we",    ram_we, 1);
    check("wr_be",    ram_be, 4'h1);
    check("wr_wdata", ram_wdata, 32'hAA);
    cyc("wr", 3'b010, 0, 0, 0);
    @(negedge clk);
    set_port(1, 1, 15'h20, 0, 4'h1, 0);
    #1;
    check("rb_be", ram_be, 4'hF);
    cyc("rb", 3'b010, 1, 1, 32'h112233AA);
    @(negedge clk);
    req = '0;
    #1;
    check("none_addr", ram_addr, 0);
    check("none_be",   ram_be, 0);
    check("none_we",   ram_we, 0);

    // Idle gaps keep round-robin pointer.
    do_reset();
    idle_req = '{3'b111, 3'b000, 3'b000,
                 3'b111, 3'b000, 3'b101,
                 3'b000, 3'b011, 3'b110,
                 3'b110, 3'b110};
    idle_exp = '{3'b001, 3'b000, 3'b000,
                 3'b010, 3'b000, 3'b100,
                 3'b000, 3'b001, 3'b010,
                 3'b100, 3'b010};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++)
        set_port(p, idle_req[i][p],
                 15'(p * 4), 0, 4'h0, 0);
      cyc($sformatf("idle%0d", i),
          idle_exp[i], 0, 0, 0);
    end

    // Reset while a response is pending.
    @(negedge clk);
    req = '0;
    set_port(0, 1, 15'h10, 0, 4'h0, 0);
    #1;
    check("mr_gnt", gnt, 3'b001);
    @(posedge clk);
    #1;
    check("mr_rv_pre", rvalid, 3'b001);
    rstn_i = 1'b0;
    req    = '0;
    #1;
    check("mr_rv_drop", rvalid, 3'b000);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    set_port(0, 1, 15'h40, 0, 4'h0, 0);
    set_port(1, 1, 15'h44, 0, 4'h0, 0);
    cyc("mr_first", 3'b001, 1, 0, 32'hA0A0A0A0);

    // Random traffic with hold-until-grant.
    @(negedge clk);
    req   = '0;
    pend  = '0;
    maxw  = 0;
    bad_g = 0;
    bad_rv = 0;
    n_g   = 0;
    n_rv  = 0;
    for (int p = 0; p < NP; p++) waitc[p] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1)
        begin
          pend[p] = 1'b1;
          set_port(p, 1,
                   15'($urandom_range(0, 4095)),
                   1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)),
                   $urandom);
        end
      end
      req = pend;
      #1;
      g = gnt;
      if (|req) begin
        if (!$onehot(g) || (g & ~req) != 0)
          bad_g++;
      end else if (g != 0) begin
        bad_g++;
      end
      for (int p = 0; p < NP; p++) begin
        if (pend[p] && !g[p]) begin
          waitc[p]++;
          if (waitc[p] > maxw) maxw = waitc[p];
        end else begin
          waitc[p] = 0;
        end
      end
      if (g != 0) n_g++;
      pend = pend & ~g;
      @(posedge clk);
      #1;
      if (rvalid !== g) bad_rv++;
      n_rv += $countones(rvalid);
    end
    @(negedge clk);
    req = '0;
    check("rnd_bad_gnt", bad_g, 0);
    check("rnd_bad_rv",  bad_rv, 0);
    check("rnd_wait_ok", maxw <= NP - 1, 1);
    check("rnd_rv_cnt",  n_rv, n_g);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
